dcache_port_arbiter: RTL and testbench

- Shares one D$ request port among NR_PORTS requesters: store buffer, load unit, PTW.
- Arbitrates data_req and returns data_gnt to the winner only.
- For reads, holds the mux on the winner for the late tag phase (address_tag/tag_valid/kill_req one cycle after grant).
- Routes each read response (rvalid/rdata) back to its issuing requester, in order.

---
 rtl/ariane_pkg.sv | 32 +++
 rtl/dcache_port_arbiter_if.sv | 30 +++
 rtl/dcache_arb_id_fifo.sv | 64 ++++++
 rtl/dcache_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - D$ request/response types and arbiter constants
package ariane_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH         = 12;
  localparam int unsigned DCACHE_TAG_WIDTH           = 20;
  localparam int unsigned XLEN                       = 64;
  localparam int unsigned DCACHE_ARB_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [XLEN/8-1:0]             data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic            data_gnt;
    logic            data_rvalid;
    logic [XLEN-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    TAG  = 1'b1
  } dcache_arb_state_e;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// rtl/dcache_port_arbiter_if.sv - requester/D$ bundle seen by the port arbiter
interface dcache_port_arbiter_if
  import ariane_pkg::*;
#(
  parameter int unsigned NR_PORTS = 3
) ();

  dcache_req_i_t [NR_PORTS-1:0] req_ports_i;
  dcache_req_o_t [NR_PORTS-1:0] req_ports_o;
  dcache_req_i_t                mem_req_o;
  dcache_req_o_t                mem_rsp_i;
  logic                         busy_o;

  modport slave (
    input  req_ports_i,
    input  mem_rsp_i,
    output req_ports_o,
    output mem_req_o,
    output busy_o
  );

  modport master (
    output req_ports_i,
    output mem_rsp_i,
    input  req_ports_o,
    input  mem_req_o,
    input  busy_o
  );

endinterface

// File: rtl/dcache_arb_id_fifo.sv
// rtl/dcache_arb_id_fifo.sv - FIFO of issuing port indices for outstanding reads
module dcache_arb_id_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  // DEPTH is a power of two, so the count MSB alone means full
  assign full_o  = count_q[PTR_W];
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pop only real entries; a full FIFO still accepts a push that pairs with a pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - shares one D$ request port among requesters; DCACHE_ARB_ROUND_ROBIN_EN selects round-robin
module dcache_port_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 3,
  parameter int unsigned MAX_OUTSTANDING = DCACHE_ARB_MAX_OUTSTANDING
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dcache_port_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  dcache_arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]              lock_idx_q, lock_idx_d;
  logic                          hold_valid_q, hold_valid_d;
  logic [IDX_W-1:0]              hold_idx_q, hold_idx_d;
  logic [NR_PORTS-1:0]           cand;
  logic [IDX_W-1:0]              winner;
  logic                          sel_valid, win_valid, granted, read_granted;
  logic                          fifo_pop, fifo_full, fifo_empty, read_block;
  logic [IDX_W-1:0]              fifo_head;
  logic [CNT_W-1:0]              fifo_count;
  dcache_req_i_t                 mem_req;
  dcache_req_o_t [NR_PORTS-1:0]  port_rsp;

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NR_PORTS) s = s - NR_PORTS;
    return IDX_W'(s);
  endfunction
`endif

  // Every response pops the head; nothing is tracked while reset is held
  assign fifo_pop   = rst_ni & bus.mem_rsp_i.data_rvalid & ~fifo_empty;
  assign read_block = fifo_full & ~fifo_pop;

  // Reads are eligible only while an outstanding slot exists this cycle
  always_comb begin
    cand = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand[i] = bus.req_ports_i[i].data_req & (bus.req_ports_i[i].data_we | ~read_block);
    end
  end

  // Choose the data-phase owner; an ungranted selection is held until granted
  always_comb begin
    winner    = '0;
    sel_valid = 1'b0;
    if (hold_valid_q && cand[hold_idx_q]) begin
      winner    = hold_idx_q;
      sel_valid = 1'b1;
    end else begin
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
        if (!sel_valid && cand[rr_idx(rr_ptr_q, k)]) begin
          winner    = rr_idx(rr_ptr_q, k);
          sel_valid = 1'b1;
        end
      end
`else
      for (int i = NR_PORTS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          winner    = IDX_W'(i);
          sel_valid = 1'b1;
        end
      end
`endif
    end
  end

  assign win_valid    = rst_ni & sel_valid;
  assign granted      = win_valid & bus.mem_rsp_i.data_gnt;
  assign read_granted = granted & ~bus.req_ports_i[winner].data_we;

  // Data phase from the winner, tag phase from the port locked on the previous read grant
  always_comb begin
    mem_req = '0;
    if (win_valid) begin
      mem_req.address_index = bus.req_ports_i[winner].address_index;
      mem_req.data_wdata    = bus.req_ports_i[winner].data_wdata;
      mem_req.data_be       = bus.req_ports_i[winner].data_be;
      mem_req.data_size     = bus.req_ports_i[winner].data_size;
      mem_req.data_we       = bus.req_ports_i[winner].data_we;
      mem_req.data_req      = 1'b1;
    end
    if (rst_ni && state_q == TAG) begin
      mem_req.address_tag = bus.req_ports_i[lock_idx_q].address_tag;
      mem_req.tag_valid   = bus.req_ports_i[lock_idx_q].tag_valid;
      mem_req.kill_req    = bus.req_ports_i[lock_idx_q].kill_req;
    end
  end

  // Grant goes to the winner only; responses go to the oldest outstanding reader
  always_comb begin
    port_rsp = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      port_rsp[i].data_gnt = granted & (winner == IDX_W'(i));
      if (fifo_pop && fifo_head == IDX_W'(i)) begin
        port_rsp[i].data_rvalid = 1'b1;
        port_rsp[i].data_rdata  = bus.mem_rsp_i.data_rdata;
      end
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.req_ports_o = port_rsp;
  assign bus.busy_o      = (state_q == TAG) | (fifo_count != '0);

  // A granted read opens a one-cycle tag phase; anything else returns to IDLE
  always_comb begin
    state_d      = read_granted ? TAG : IDLE;
    lock_idx_d   = read_granted ? winner : lock_idx_q;
    hold_valid_d = win_valid & ~granted;
    hold_idx_d   = winner;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
    if (granted) begin
      rr_ptr_d = (32'(winner) + 1 >= NR_PORTS) ? '0 : winner + 1'b1;
    end
`endif
  end

  // Arbiter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      lock_idx_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_idx_q   <= '0;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lock_idx_q   <= lock_idx_d;
      hold_valid_q <= hold_valid_d;
      hold_idx_q   <= hold_idx_d;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  dcache_arb_id_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (read_granted),
    .data_i  (winner),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A response with no outstanding read has nowhere to go
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(bus.mem_rsp_i.data_rvalid && fifo_empty))
    else $error("dcache_port_arbiter: rvalid with no outstanding read");

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - bench for dcache_port_arbiter: reference model, directed cases, random traffic
module tb_dcache_port_arbiter;
  import ariane_pkg::*;

  localparam int NP   = 3;
  localparam int MAXO = DCACHE_ARB_MAX_OUTSTANDING;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  dcache_port_arbiter_if #(.NR_PORTS(NP)) bus ();

  dcache_port_arbiter #(
    .NR_PORTS        (NP),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: queue of reader ports, pending tag phase, rr pointer, held selection
  int mq[$];
  bit m_tag    = 0;
  int m_lock   = 0;
  int m_rr     = 0;
  bit m_hold   = 0;
  int m_hold_i = 0;
  bit m_gnt [NP];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model compare, every cycle
  always @(negedge clk) begin : cmp
    int w;
    int j;
    int head;
    bit pop;
    bit blk;
    bit g;
    bit cand [NP];
    dcache_req_i_t rq;
    if (!rst_ni) begin
      mq.delete();
      m_tag = 0; m_lock = 0; m_rr = 0; m_hold = 0; m_hold_i = 0;
      chk("rst_mem_req", 128'(bus.mem_req_o), 128'd0);
      chk("rst_busy", 128'(bus.busy_o), 128'd0);
      for (int i = 0; i < NP; i++) begin
        m_gnt[i] = 0;
        chk($sformatf("rst_port_rsp[%0d]", i), 128'(bus.req_ports_o[i]), 128'd0);
      end
    end else begin
      pop  = bus.mem_rsp_i.data_rvalid && (mq.size() > 0);
      blk  = (mq.size() == MAXO) && !pop;
      head = (mq.size() > 0) ? mq[0] : -1;
      for (int i = 0; i < NP; i++)
        cand[i] = bus.req_ports_i[i].data_req && (bus.req_ports_i[i].data_we || !blk);
      w = -1;
      if (m_hold && cand[m_hold_i]) w = m_hold_i;
      else begin
        for (int k = 0; k < NP; k++) begin
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
          j = (m_rr + k) % NP;
`else
          j = k;
`endif
          if (w < 0 && cand[j]) w = j;
        end
      end
      g = (w >= 0) && bus.mem_rsp_i.data_gnt;
      rq = (w >= 0) ? bus.req_ports_i[w] : '0;

      chk("mem_data_req", 128'(bus.mem_req_o.data_req), 128'(w >= 0));
      if (w >= 0) begin
        chk("mem_index", 128'(bus.mem_req_o.address_index), 128'(rq.address_index));
        chk("mem_wdata", 128'(bus.mem_req_o.data_wdata), 128'(rq.data_wdata));
        chk("mem_be", 128'(bus.mem_req_o.data_be), 128'(rq.data_be));
        chk("mem_size", 128'(bus.mem_req_o.data_size), 128'(rq.data_size));
        chk("mem_we", 128'(bus.mem_req_o.data_we), 128'(rq.data_we));
      end
      if (m_tag) begin
        chk("mem_tag_valid", 128'(bus.mem_req_o.tag_valid), 128'(bus.req_ports_i[m_lock].tag_valid));
        chk("mem_kill", 128'(bus.mem_req_o.kill_req), 128'(bus.req_ports_i[m_lock].kill_req));
        chk("mem_tag", 128'(bus.mem_req_o.address_tag), 128'(bus.req_ports_i[m_lock].address_tag));
      end else begin
        chk("idle_tag_valid", 128'(bus.mem_req_o.tag_valid), 128'd0);
        chk("idle_kill", 128'(bus.mem_req_o.kill_req), 128'd0);
      end
      for (int i = 0; i < NP; i++) begin
        m_gnt[i] = g && (w == i);
        chk($sformatf("gnt[%0d]", i), 128'(bus.req_ports_o[i].data_gnt), 128'(m_gnt[i]));
        chk($sformatf("rvalid[%0d]", i), 128'(bus.req_ports_o[i].data_rvalid), 128'(pop && head == i));
        if (pop && head == i)
          chk($sformatf("rdata[%0d]", i), 128'(bus.req_ports_o[i].data_rdata), 128'(bus.mem_rsp_i.data_rdata));
      end
      chk("busy", 128'(bus.busy_o), 128'(m_tag || mq.size() != 0));

      if (pop) void'(mq.pop_front());
      if (g && !rq.data_we) mq.push_back(w);
      m_tag = g && !rq.data_we;
      if (m_tag) m_lock = w;
      if (g) m_rr = (w + 1) % NP;
      m_hold   = (w >= 0) && !g;
      m_hold_i = w;
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NP; i++) bus.req_ports_i[i] = '0;
    bus.mem_rsp_i = '0;
  endtask

  task automatic do_reset();
    to_drive();
    clear_inputs();
    rst_ni = 1'b0;
    to_neg();
    to_drive();
    rst_ni = 1'b1;
  endtask

  task automatic set_read(input int p, input logic [11:0] idx);
    bus.req_ports_i[p].data_req      = 1'b1;
    bus.req_ports_i[p].data_we       = 1'b0;
    bus.req_ports_i[p].address_index = idx;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    to_neg();
    chk("reset_busy", 128'(bus.busy_o), 128'd0);
    chk("reset_mem_req", 128'(bus.mem_req_o.data_req), 128'd0);
    to_drive();
    rst_ni = 1'b1;

    // single write from port 1
    bus.req_ports_i[1].data_req      = 1'b1;
    bus.req_ports_i[1].data_we       = 1'b1;
    bus.req_ports_i[1].address_index = 12'h155;
    bus.req_ports_i[1].data_wdata    = 64'hDEAD_BEEF_0123_4567;
    bus.req_ports_i[1].data_be       = 8'hF0;
    bus.req_ports_i[1].data_size     = 2'd3;
    bus.mem_rsp_i.data_gnt           = 1'b1;
    to_neg();
    chk("t1_req", 128'(bus.mem_req_o.data_req), 128'd1);
    chk("t1_index", 128'(bus.mem_req_o.address_index), 128'h155);
    chk("t1_wdata", 128'(bus.mem_req_o.data_wdata), 128'hDEAD_BEEF_0123_4567);
    chk("t1_gnt1", 128'(bus.req_ports_o[1].data_gnt), 128'd1);
    chk("t1_gnt0", 128'(bus.req_ports_o[0].data_gnt), 128'd0);
    chk("t1_busy", 128'(bus.busy_o), 128'd0);
    to_drive();
    bus.req_ports_i[1] = '0;
    to_neg();
    chk("t1_busy_after", 128'(bus.busy_o), 128'd0);
    chk("t1_tag_valid_after", 128'(bus.mem_req_o.tag_valid), 128'd0);

    // reads on ports 0 and 2, tags follow one cycle later, responses in order
    do_reset();
    set_read(0, 12'h010);
    set_read(2, 12'h0F2);
    bus.mem_rsp_i.data_gnt = 1'b1;
    to_neg();
    chk("t2_gnt0_c0", 128'(bus.req_ports_o[0].data_gnt), 128'd1);
    chk("t2_gnt2_c0", 128'(bus.req_ports_o[2].data_gnt), 128'd0);
    chk("t2_index_c0", 128'(bus.mem_req_o.address_index), 128'h010);
    to_drive();
    bus.req_ports_i[0].data_req    = 1'b0;
    bus.req_ports_i[0].tag_valid   = 1'b1;
    bus.req_ports_i[0].address_tag = 20'hABCDE;
    to_neg();
    chk("t2_gnt2_c1", 128'(bus.req_ports_o[2].data_gnt), 128'd1);
    chk("t2_index_c1", 128'(bus.mem_req_o.address_index), 128'h0F2);
    chk("t2_tag_c1", 128'(bus.mem_req_o.address_tag), 128'hABCDE);
    chk("t2_tag_valid_c1", 128'(bus.mem_req_o.tag_valid), 128'd1);
    chk("t2_busy_c1", 128'(bus.busy_o), 128'd1);
    to_drive();
    bus.req_ports_i[2].data_req    = 1'b0;
    bus.req_ports_i[2].tag_valid   = 1'b1;
    bus.req_ports_i[2].address_tag = 20'h12345;
    bus.req_ports_i[0].tag_valid   = 1'b0;
    to_neg();
    chk("t2_tag_c2", 128'(bus.mem_req_o.address_tag), 128'h12345);
    chk("t2_tag_valid_c2", 128'(bus.mem_req_o.tag_valid), 128'd1);
    to_drive();
    bus.req_ports_i[2].tag_valid = 1'b0;
    bus.mem_rsp_i.data_rvalid    = 1'b1;
    bus.mem_rsp_i.data_rdata     = 64'hA;
    to_neg();
    chk("t2_rvalid0", 128'(bus.req_ports_o[0].data_rvalid), 128'd1);
    chk("t2_rdata0", 128'(bus.req_ports_o[0].data_rdata), 128'hA);
    chk("t2_rvalid2_early", 128'(bus.req_ports_o[2].data_rvalid), 128'd0);
    to_drive();
    bus.mem_rsp_i.data_rdata = 64'hB;
    to_neg();
    chk("t2_rvalid2", 128'(bus.req_ports_o[2].data_rvalid), 128'd1);
    chk("t2_rdata2", 128'(bus.req_ports_o[2].data_rdata), 128'hB);
    chk("t2_rvalid0_late", 128'(bus.req_ports_o[0].data_rvalid), 128'd0);
    to_drive();
    bus.mem_rsp_i.data_rvalid = 1'b0;
    to_neg();
    chk("t2_busy_end", 128'(bus.busy_o), 128'd0);

    // all ports writing continuously
    do_reset();
    for (int i = 0; i < NP; i++) begin
      bus.req_ports_i[i].data_req      = 1'b1;
      bus.req_ports_i[i].data_we       = 1'b1;
      bus.req_ports_i[i].address_index = 12'(i);
    end
    bus.mem_rsp_i.data_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      to_neg();
      for (int i = 0; i < NP; i++) begin
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
        chk($sformatf("t3_rr_gnt[%0d]@%0d", i, k), 128'(bus.req_ports_o[i].data_gnt), 128'(i == k % 3));
`else
        chk($sformatf("t3_fp_gnt[%0d]@%0d", i, k), 128'(bus.req_ports_o[i].data_gnt), 128'(i == 0));
`endif
      end
      to_drive();
    end

    // fill all outstanding slots, then a read waits while a write passes
    do_reset();
    bus.mem_rsp_i.data_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_read(1, 12'(k));
      to_neg();
      chk($sformatf("t4_fill_gnt1@%0d", k), 128'(bus.req_ports_o[1].data_gnt), 128'd1);
      to_drive();
    end
    set_read(1, 12'h5);
    bus.req_ports_i[2].data_req = 1'b1;
    bus.req_ports_i[2].data_we  = 1'b1;
    to_neg();
    chk("t4_blocked_gnt1", 128'(bus.req_ports_o[1].data_gnt), 128'd0);
    chk("t4_write_gnt2", 128'(bus.req_ports_o[2].data_gnt), 128'd1);
    chk("t4_busy", 128'(bus.busy_o), 128'd1);
    to_drive();
    bus.req_ports_i[2]        = '0;
    bus.mem_rsp_i.data_rvalid = 1'b1;
    bus.mem_rsp_i.data_rdata  = 64'h77;
    to_neg();
    chk("t4_pushpop_gnt1", 128'(bus.req_ports_o[1].data_gnt), 128'd1);
    chk("t4_pushpop_rvalid1", 128'(bus.req_ports_o[1].data_rvalid), 128'd1);
    to_drive();
    bus.mem_rsp_i.data_rvalid = 1'b0;
    set_read(1, 12'h6);
    to_neg();
    chk("t4_still_full_gnt1", 128'(bus.req_ports_o[1].data_gnt), 128'd0);
    to_drive();
    bus.req_ports_i[1] = '0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rsp_i.data_rvalid = 1'b1;
      bus.mem_rsp_i.data_rdata  = 64'(256 + k);
      to_neg();
      chk($sformatf("t4_drain_rvalid1@%0d", k), 128'(bus.req_ports_o[1].data_rvalid), 128'd1);
      to_drive();
    end
    bus.mem_rsp_i.data_rvalid = 1'b0;
    to_neg();
    chk("t4_busy_end", 128'(bus.busy_o), 128'd0);

    // killed read still returns its response to port 2
    do_reset();
    set_read(2, 12'h0AA);
    bus.mem_rsp_i.data_gnt = 1'b1;
    to_neg();
    chk("t5_gnt2", 128'(bus.req_ports_o[2].data_gnt), 128'd1);
    to_drive();
    bus.req_ports_i[2].data_req  = 1'b0;
    bus.req_ports_i[2].tag_valid = 1'b1;
    bus.req_ports_i[2].kill_req  = 1'b1;
    to_neg();
    chk("t5_kill", 128'(bus.mem_req_o.kill_req), 128'd1);
    to_drive();
    bus.req_ports_i[2].tag_valid = 1'b0;
    bus.req_ports_i[2].kill_req  = 1'b0;
    bus.mem_rsp_i.data_rvalid    = 1'b1;
    bus.mem_rsp_i.data_rdata     = 64'hC;
    to_neg();
    chk("t5_rvalid2", 128'(bus.req_ports_o[2].data_rvalid), 128'd1);
    chk("t5_rdata2", 128'(bus.req_ports_o[2].data_rdata), 128'hC);
    to_drive();
    bus.mem_rsp_i.data_rvalid = 1'b0;
    to_neg();
    chk("t5_busy_end", 128'(bus.busy_o), 128'd0);

    // reset with two reads outstanding
    do_reset();
    set_read(0, 12'h033);
    bus.mem_rsp_i.data_gnt = 1'b1;
    to_drive();
    to_drive();
    rst_ni = 1'b0;
    to_neg();
    chk("t6_busy", 128'(bus.busy_o), 128'd0);
    chk("t6_mem_req", 128'(bus.mem_req_o.data_req), 128'd0);
    chk("t6_gnt0", 128'(bus.req_ports_o[0].data_gnt), 128'd0);
    chk("t6_tag_valid", 128'(bus.mem_req_o.tag_valid), 128'd0);
    to_drive();
    bus.mem_rsp_i.data_rvalid = 1'b1;
    bus.mem_rsp_i.data_rdata  = 64'h55;
    to_neg();
    for (int i = 0; i < NP; i++)
      chk($sformatf("t6_rvalid[%0d]", i), 128'(bus.req_ports_o[i].data_rvalid), 128'd0);
    to_drive();
    clear_inputs();
    rst_ni = 1'b1;

    // random traffic; requesters hold payload until the model reports a grant
    for (int c = 0; c < 3000; c++) begin
      to_drive();
      for (int i = 0; i < NP; i++) begin
        if (!bus.req_ports_i[i].data_req || m_gnt[i]) begin
          bus.req_ports_i[i].data_req      = ($urandom_range(0, 99) < 55);
          bus.req_ports_i[i].data_we       = ($urandom_range(0, 99) < 40);
          bus.req_ports_i[i].address_index = 12'($urandom);
          bus.req_ports_i[i].data_wdata    = {$urandom, $urandom};
          bus.req_ports_i[i].data_be       = 8'($urandom);
          bus.req_ports_i[i].data_size     = 2'($urandom);
        end
        bus.req_ports_i[i].address_tag = 20'($urandom);
        bus.req_ports_i[i].tag_valid   = 1'($urandom);
        bus.req_ports_i[i].kill_req    = 1'($urandom);
      end
      bus.mem_rsp_i.data_gnt    = ($urandom_range(0, 3) != 0);
      bus.mem_rsp_i.data_rvalid = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
      bus.mem_rsp_i.data_rdata  = {$urandom, $urandom};
    end
    to_drive();
    clear_inputs();
    to_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
